// File: rtl/rtc_bus_responder.sv
// rtl/rtc_bus_responder.sv - BCD real-time clock and countdown timer behind a multiplexed address/data bus
module rtc_bus_responder #(
  parameter logic [7:0] ADDR_CLR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       CS_n,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic       A_D,
  input  logic [7:0] AD_in,
  output logic [7:0] AD_out,
  output logic       AD_oe,
  output logic       IRQ_n
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, WAIT_REL} state_t;

  state_t     state;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [2:0] widx;
  logic [7:0] tm_live [0:5];
  logic [7:0] tm_shad [0:5];
  logic [7:0] tm_next [0:5];
  logic [7:0] tr_live [0:2];
  logic [7:0] tr_shad [0:2];
  logic [7:0] tr_next [0:2];
  logic       armed;
  logic [5:1] carry;
  logic [2:1] borrow;
  logic       commit;
  logic       time_load;
  logic       timer_load;
  logic       irq_clr;
  logic       t_zero;
  logic       t_end;
  logic       expire;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v,
                                         input logic [7:0] wrap_v);
    if (v == max_v)           return wrap_v;
    else if (v[3:0] == 4'h9)  return {v[7:4] + 4'h1, 4'h0};
    else                      return v + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap_v);
    if (v == 8'h00)           return wrap_v;
    else if (v[3:0] == 4'h0)  return {v[7:4] - 4'h1, 4'h9};
    else                      return v - 8'h01;
  endfunction

  // A write commits in the cycle the initiator releases the strobe or chip select.
  assign commit     = (state == WDATA) && (WR_n || CS_n);
  assign time_load  = commit && (addr == 8'hF0) && (wdata == 8'hF0);
  assign timer_load = commit && (addr == 8'hF0) && (wdata == 8'hF1);
  assign irq_clr    = commit && (addr == ADDR_CLR) && wdata[0];
  assign widx       = addr[2:0] - 3'd1;

  assign carry[1]  = (tm_live[0] == 8'h59);
  assign carry[2]  = carry[1] && (tm_live[1] == 8'h59);
  assign carry[3]  = carry[2] && (tm_live[2] == 8'h23);
  assign carry[4]  = carry[3] && (tm_live[3] == 8'h31);
  assign carry[5]  = carry[4] && (tm_live[4] == 8'h12);
  assign borrow[1] = (tr_live[0] == 8'h00);
  assign borrow[2] = borrow[1] && (tr_live[1] == 8'h00);

  always_comb begin
    tm_next[0] = bcd_inc(tm_live[0], 8'h59, 8'h00);
    tm_next[1] = carry[1] ? bcd_inc(tm_live[1], 8'h59, 8'h00) : tm_live[1];
    tm_next[2] = carry[2] ? bcd_inc(tm_live[2], 8'h23, 8'h00) : tm_live[2];
    tm_next[3] = carry[3] ? bcd_inc(tm_live[3], 8'h31, 8'h01) : tm_live[3];
    tm_next[4] = carry[4] ? bcd_inc(tm_live[4], 8'h12, 8'h01) : tm_live[4];
    tm_next[5] = carry[5] ? bcd_inc(tm_live[5], 8'h99, 8'h00) : tm_live[5];
    tr_next[0] = bcd_dec(tr_live[0], 8'h59);
    tr_next[1] = borrow[1] ? bcd_dec(tr_live[1], 8'h59) : tr_live[1];
    tr_next[2] = borrow[2] ? bcd_dec(tr_live[2], 8'h23) : tr_live[2];
  end

  assign t_zero = borrow[2] && (tr_live[2] == 8'h00);
  assign t_end  = (tr_next[0] == 8'h00) && (tr_next[1] == 8'h00) && (tr_next[2] == 8'h00);
  assign expire = tick_1hz && armed && !timer_load && (t_zero || t_end);

  always_comb begin
    rdata = 8'h00;
    case (addr)
      8'h21:   rdata = tm_live[0];
      8'h22:   rdata = tm_live[1];
      8'h23:   rdata = tm_live[2];
      8'h24:   rdata = tm_live[3];
      8'h25:   rdata = tm_live[4];
      8'h26:   rdata = tm_live[5];
      8'h41:   rdata = tr_live[0];
      8'h42:   rdata = tr_live[1];
      8'h43:   rdata = tr_live[2];
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= 8'h00;
      wdata  <= 8'h00;
      AD_out <= 8'h00;
      AD_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!CS_n) begin
            if (!RD_n && !WR_n) begin
              state <= WAIT_REL;
            end else if (!WR_n) begin
              if (A_D) begin
                wdata <= AD_in;
                state <= WDATA;
              end else begin
                addr  <= AD_in;
                state <= ADDR;
              end
            end else if (!RD_n && A_D) begin
              state  <= RDATA;
              AD_oe  <= 1'b1;
              AD_out <= rdata;
            end
          end
        end
        ADDR: begin
          if (WR_n || CS_n) state <= IDLE;
          else              addr  <= AD_in;
        end
        WDATA: begin
          if (WR_n || CS_n) state <= IDLE;
          else              wdata <= AD_in;
        end
        RDATA: begin
          if (RD_n || CS_n) begin
            state  <= IDLE;
            AD_oe  <= 1'b0;
            AD_out <= 8'h00;
          end else begin
            AD_out <= rdata;
          end
        end
        WAIT_REL: begin
          if (CS_n && RD_n && WR_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A load command overrides a same-cycle tick for its own register group only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        tm_live[i] <= 8'h00;
        tm_shad[i] <= 8'h00;
      end
      tm_live[3] <= 8'h01;
      tm_live[4] <= 8'h01;
      tm_shad[3] <= 8'h01;
      tm_shad[4] <= 8'h01;
      for (int i = 0; i < 3; i++) begin
        tr_live[i] <= 8'h00;
        tr_shad[i] <= 8'h00;
      end
      armed <= 1'b0;
      IRQ_n <= 1'b1;
    end else begin
      if (commit && (addr >= 8'h21) && (addr <= 8'h26)) tm_shad[widx] <= wdata;
      if (commit && (addr >= 8'h41) && (addr <= 8'h43)) tr_shad[widx[1:0]] <= wdata;
      if (time_load)     tm_live <= tm_shad;
      else if (tick_1hz) tm_live <= tm_next;
      if (timer_load) begin
        tr_live <= tr_shad;
        armed   <= 1'b1;
      end else if (tick_1hz && armed) begin
        if (!t_zero) tr_live <= tr_next;
        if (expire)  armed   <= 1'b0;
      end
      if (expire)       IRQ_n <= 1'b0;
      else if (irq_clr) IRQ_n <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb/tb_rtc_bus_responder.sv - scoreboard bench for rtc_bus_responder against a decimal-arithmetic clock model
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A_D;
  logic [7:0] AD_in;
  logic [7:0] AD_out;
  logic       AD_oe;
  logic       IRQ_n;

  rtc_bus_responder #(.ADDR_CLR(8'h00)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n),
    .A_D(A_D), .AD_in(AD_in), .AD_out(AD_out), .AD_oe(AD_oe), .IRQ_n(IRQ_n)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_tm_live [0:5];
  logic [7:0] m_tm_shad [0:5];
  logic [7:0] m_tr_live [0:2];
  logic [7:0] m_tr_shad [0:2];
  bit         m_armed;
  bit         m_irq;
  logic [7:0] m_addr;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int b2i(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] i2b(input int x);
    logic [3:0] hi, lo;
    hi = 4'(x / 10);
    lo = 4'(x % 10);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_tm_live[i] = (i == 3 || i == 4) ? 8'h01 : 8'h00;
      m_tm_shad[i] = m_tm_live[i];
    end
    for (int i = 0; i < 3; i++) begin
      m_tr_live[i] = 8'h00;
      m_tr_shad[i] = 8'h00;
    end
    m_armed = 0;
    m_irq   = 0;
    m_addr  = 8'h00;
  endtask

  task automatic model_tick_time();
    int s, mi, h, d, mo, y;
    s = b2i(m_tm_live[0]); mi = b2i(m_tm_live[1]); h = b2i(m_tm_live[2]);
    d = b2i(m_tm_live[3]); mo = b2i(m_tm_live[4]); y = b2i(m_tm_live[5]);
    s++;
    if (s == 60) begin
      s = 0; mi++;
      if (mi == 60) begin
        mi = 0; h++;
        if (h == 24) begin
          h = 0; d++;
          if (d == 32) begin
            d = 1; mo++;
            if (mo == 13) begin
              mo = 1; y = (y + 1) % 100;
            end
          end
        end
      end
    end
    m_tm_live[0] = i2b(s); m_tm_live[1] = i2b(mi); m_tm_live[2] = i2b(h);
    m_tm_live[3] = i2b(d); m_tm_live[4] = i2b(mo); m_tm_live[5] = i2b(y);
  endtask

  task automatic model_tick_timer(output bit expired);
    int total;
    expired = 0;
    if (m_armed) begin
      total = b2i(m_tr_live[2]) * 3600 + b2i(m_tr_live[1]) * 60 + b2i(m_tr_live[0]);
      if (total > 0) total--;
      if (total == 0) begin
        m_armed = 0;
        m_irq   = 1;
        expired = 1;
      end
      m_tr_live[2] = i2b(total / 3600);
      m_tr_live[1] = i2b((total / 60) % 60);
      m_tr_live[0] = i2b(total % 60);
    end
  endtask

  task automatic model_commit(input logic [7:0] a, input logic [7:0] d, input bit tick);
    bit time_ld, tmr_ld, exp_now;
    time_ld = (a == 8'hF0) && (d == 8'hF0);
    tmr_ld  = (a == 8'hF0) && (d == 8'hF1);
    exp_now = 0;
    if (tick && !time_ld) model_tick_time();
    if (tick && !tmr_ld)  model_tick_timer(exp_now);
    if (a == 8'h00 && d[0] && !exp_now) m_irq = 0;
    if (a >= 8'h21 && a <= 8'h26) m_tm_shad[a - 8'h21] = d;
    if (a >= 8'h41 && a <= 8'h43) m_tr_shad[a - 8'h41] = d;
    if (time_ld) m_tm_live = m_tm_shad;
    if (tmr_ld) begin
      m_tr_live = m_tr_shad;
      m_armed   = 1;
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a >= 8'h21 && a <= 8'h26) return m_tm_live[a - 8'h21];
    if (a >= 8'h41 && a <= 8'h43) return m_tr_live[a - 8'h41];
    return 8'h00;
  endfunction

  function automatic logic [7:0] rand_legal(input int idx);
    int v;
    case (idx)
      0, 1:    v = int'($urandom_range(0, 59));
      2:       v = int'($urandom_range(0, 23));
      3:       v = int'($urandom_range(1, 31));
      4:       v = int'($urandom_range(1, 12));
      default: v = int'($urandom_range(0, 99));
    endcase
    return i2b(v);
  endfunction

  // Monitor: every rising edge of AD_oe is one read response to score.
  bit prev_oe = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (AD_oe && !prev_oe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got AD_out=%h expected no read at %0t", AD_out, $time);
        end else begin
          check("read_data", AD_out, exp_q.pop_front());
        end
      end
      prev_oe = AD_oe;
    end
  end

  task automatic set_addr(input logic [7:0] a);
    CS_n = 0; A_D = 0; WR_n = 0; AD_in = 8'($urandom);
    @(negedge clk);
    AD_in = a;
    @(negedge clk);
    CS_n = 1; WR_n = 1; AD_in = 8'($urandom);
    @(negedge clk);
    m_addr = a;
  endtask

  task automatic write_data(input logic [7:0] d, input bit tick);
    CS_n = 0; A_D = 1; WR_n = 0; AD_in = 8'($urandom);
    @(negedge clk);
    AD_in = d;
    @(negedge clk);
    CS_n = 1; WR_n = 1; tick_1hz = tick;
    @(negedge clk);
    tick_1hz = 0;
    model_commit(m_addr, d, tick);
    check("irq_after_write", IRQ_n, !m_irq);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit tick);
    set_addr(a);
    write_data(d, tick);
  endtask

  task automatic rd(input logic [7:0] a);
    set_addr(a);
    CS_n = 0; A_D = 1; RD_n = 0;
    exp_q.push_back(m_read(a));
    repeat (3) @(negedge clk);
    check("oe_during_read", AD_oe, 1);
    RD_n = 1; CS_n = 1;
    @(negedge clk);
    check("oe_after_read", AD_oe, 0);
  endtask

  task automatic do_ticks(input int n);
    bit e;
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1;
      @(negedge clk);
      tick_1hz = 0;
      model_tick_time();
      model_tick_timer(e);
      check("irq_after_tick", IRQ_n, !m_irq);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; tick_1hz = 0; CS_n = 1; RD_n = 1; WR_n = 1; A_D = 0; AD_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_oe", AD_oe, 0);
    check("reset_out", AD_out, 8'h00);
    check("reset_irq", IRQ_n, 1);
    rst = 0;
    @(negedge clk);
    rd(8'h24); rd(8'h25); rd(8'h21); rd(8'h41);

    // Shadow write is invisible until transferred; unmapped reads are zero.
    wr(8'h21, 8'h30, 0); rd(8'h21); rd(8'h7F);
    wr(8'h21, 8'h45, 0); wr(8'hF0, 8'hF0, 0); rd(8'h21);

    // Full rollover of every time field.
    wr(8'h21, 8'h59, 0); wr(8'h22, 8'h59, 0); wr(8'h23, 8'h23, 0);
    wr(8'h24, 8'h31, 0); wr(8'h25, 8'h12, 0); wr(8'h26, 8'h99, 0);
    wr(8'hF0, 8'hF0, 0);
    do_ticks(1);
    for (int i = 0; i < 6; i++) rd(8'h21 + 8'(i));

    // Timer 00:00:02 expires on the second tick; bit0=0 does not clear.
    wr(8'h41, 8'h02, 0); wr(8'h42, 8'h00, 0); wr(8'h43, 8'h00, 0);
    wr(8'hF0, 8'hF1, 0);
    do_ticks(2);
    rd(8'h41);
    wr(8'h00, 8'h02, 0);
    wr(8'h00, 8'h01, 0);

    // Load commands beat a coincident tick for their own group.
    wr(8'h21, 8'h10, 0); wr(8'hF0, 8'hF0, 1); rd(8'h21);
    wr(8'h41, 8'h05, 0); wr(8'hF0, 8'hF1, 1); rd(8'h41); rd(8'h21);

    // Expiry beats a coincident clear.
    wr(8'h41, 8'h01, 0); wr(8'h42, 8'h00, 0); wr(8'hF0, 8'hF1, 0);
    do_ticks(1);
    wr(8'hF0, 8'hF1, 0);
    wr(8'h00, 8'h01, 1);
    wr(8'h00, 8'h01, 0);

    // Both strobes low: no access, stays parked until all release.
    set_addr(8'h22);
    CS_n = 0; A_D = 1; RD_n = 0; WR_n = 0; AD_in = 8'h11;
    repeat (3) @(negedge clk);
    check("wait_rel_oe", AD_oe, 0);
    WR_n = 1;
    repeat (2) @(negedge clk);
    check("wait_rel_rd_only_oe", AD_oe, 0);
    RD_n = 1; WR_n = 0;
    repeat (2) @(negedge clk);
    CS_n = 1; WR_n = 1;
    repeat (2) @(negedge clk);
    wr(8'hF0, 8'hF0, 0); rd(8'h22);

    // Reset in the middle of a data phase aborts the write.
    set_addr(8'h22);
    CS_n = 0; A_D = 1; WR_n = 0; AD_in = 8'h37;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    CS_n = 1; WR_n = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    check("irq_after_midreset", IRQ_n, 1);
    wr(8'hF0, 8'hF0, 0); rd(8'h22); rd(8'h24);
    wr(8'h22, 8'h15, 0); wr(8'hF0, 8'hF0, 0); rd(8'h22);

    // Illegal BCD passes through untouched, then restore legal values.
    wr(8'h21, 8'h3A, 0); wr(8'h26, 8'hAB, 0); wr(8'hF0, 8'hF0, 0);
    rd(8'h21); rd(8'h26);
    wr(8'h21, 8'h00, 0); wr(8'h26, 8'h00, 0); wr(8'hF0, 8'hF0, 0);

    for (int it = 0; it < 60; it++) begin
      int op, idx;
      op = int'($urandom_range(0, 4));
      case (op)
        0: begin
          idx = int'($urandom_range(0, 5));
          wr(8'h21 + 8'(idx), rand_legal(idx), 0);
        end
        1: begin
          idx = int'($urandom_range(0, 2));
          wr(8'h41 + 8'(idx), (idx == 0) ? rand_legal(0) : i2b(int'($urandom_range(0, idx == 1 ? 1 : 0))), 0);
        end
        2: begin
          idx = int'($urandom_range(0, 2));
          if (idx == 0)      wr(8'hF0, 8'hF0, 1'($urandom_range(0, 1)));
          else if (idx == 1) wr(8'hF0, 8'hF1, 1'($urandom_range(0, 1)));
          else               wr(8'h00, 8'($urandom), 1'($urandom_range(0, 1)));
        end
        3: do_ticks(int'($urandom_range(1, 5)));
        default: begin
          idx = int'($urandom_range(0, 9));
          if (idx < 6)      rd(8'h21 + 8'(idx));
          else if (idx < 9) rd(8'h41 + 8'(idx - 6));
          else              rd(8'($urandom));
        end
      endcase
    end

    repeat (3) @(negedge clk);
    check("read_queue_drained", exp_q.size(), 0);
    check("final_irq", IRQ_n, !m_irq);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port tick_1hz, input, 1, one-clk strobe per second that advances time and timer.
REQ-004 SHALL have port CS_n, input, 1, chip select, active low.
REQ-005 SHALL have port RD_n, input, 1, read strobe, active low.
REQ-006 SHALL have port WR_n, input, 1, write strobe, active low.
REQ-007 SHALL have port A_D, input, 1, bus phase; 0 = address phase, 1 = data phase.
REQ-008 SHALL have port AD_in, input, 8, multiplexed address/data from the initiator.
REQ-009 SHALL have port AD_out, output, 8, read data to the initiator.
REQ-010 SHALL have port AD_oe, output, 1, AD_out drive enable.
REQ-011 SHALL have port IRQ_n, output, 1, timer-expiry interrupt, active low.
REQ-012 SHALL have parameter ADDR_CLR, default 8'h00, address whose data bit0 = 1 clears the IRQ.

Function
REQ-013 SHALL sample all bus inputs on clk; the inputs are already synchronous to clk.
REQ-014 SHALL implement bus FSM states IDLE, ADDR, WDATA, RDATA, WAIT_REL.
REQ-015 IDLE -> ADDR when CS_n=0, A_D=0, WR_n=0; ADDR SHALL latch AD_in each cycle and return to IDLE on WR_n=1 or CS_n=1; the last value latched is the address.
REQ-016 IDLE -> WDATA when CS_n=0, A_D=1, WR_n=0; WDATA SHALL latch AD_in each cycle and commit the write in the cycle WR_n=1 or CS_n=1 is sampled, then return to IDLE.
REQ-017 IDLE -> RDATA when CS_n=0, A_D=1, RD_n=0; RDATA SHALL hold AD_oe=1 and AD_out=register[address], registered, one cycle after entry; on RD_n=1 or CS_n=1, AD_oe SHALL drop in the next cycle and the FSM SHALL return to IDLE.
REQ-018 RD_n=0 and WR_n=0 together in IDLE SHALL enter WAIT_REL with no access; WAIT_REL SHALL exit to IDLE only when both strobes and CS_n are high.
REQ-019 SHALL decode live registers 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year, 0x41 timer sec, 0x42 timer min, 0x43 timer hour, all BCD.
REQ-020 Writes to 0x21-0x26 and 0x41-0x43 SHALL go to shadow registers only; reads SHALL return live values.
REQ-021 Write of 8'hF0 to address 0xF0 SHALL copy the time shadow to live time; write of 8'hF1 to 0xF0 SHALL copy the timer shadow to live timer and arm the timer.
REQ-022 Reads of unmapped addresses SHALL return 8'h00; writes to them SHALL be ignored.
REQ-023 On tick_1hz, live time SHALL advance in BCD: sec 59->00 carries to min, min 59->00 to hour, hour 23->00 to day, day 31->01 to month, month 12->01 to year, year 99->00.
REQ-024 On tick_1hz with timer armed, the live timer SHALL decrement in BCD (sec 00->59 borrows min, min 00->59 borrows hour); at 00:00:00 the timer SHALL disarm and IRQ_n SHALL go 0 the next cycle.
REQ-025 A transfer write and a tick_1hz in the same cycle: the transfer SHALL win and that tick SHALL be discarded for the affected register group.
REQ-026 IRQ_n SHALL stay 0 until a write to ADDR_CLR with bit0 = 1; if that clear and a new expiry occur in the same cycle, the expiry SHALL win and IRQ_n stays 0.
REQ-027 A BCD shadow value with an illegal nibble SHALL be transferred as written, without correction.

Reset
REQ-028 While rst = 1, the FSM SHALL be in IDLE, AD_out = 8'h00, AD_oe = 0, IRQ_n = 1, and the timer disarmed.
REQ-029 While rst = 1, live and shadow registers SHALL be 8'h00, except day and month, which SHALL be 8'h01.
REQ-030 rst asserted mid-transfer SHALL abort the access with no commit; the first access after release SHALL start from IDLE.

Verification
REQ-031 Address phase 0x21, then data write 0x45, then write 0xF0 to address 0xF0, then read 0x21 -> AD_out = 8'h45 with AD_oe = 1 during RD_n low.
REQ-032 Live time 23:59:59 on day 31, month 12, year 99, plus one tick_1hz -> 00:00:00, day 01, month 01, year 00.
REQ-033 Timer loaded 00:00:02 via 0xF1 command, then 2 ticks -> IRQ_n = 0 one cycle after the 2nd tick; write 0x01 to 0x00 -> IRQ_n = 1.
REQ-034 Read of 0x21 before any transfer after a shadow write of 0x30 -> 8'h00; read of unmapped 0x7F -> 8'h00.
REQ-035 RD_n and WR_n low together -> no register change, AD_oe = 0, and the FSM stays in WAIT_REL until all strobes are high.
REQ-036 rst pulsed during WDATA on address 0x22 -> shadow minute = 8'h00 and the next normal write commits.
